// File: rtl/bit_word_packer_if.sv
// Word-packer bus: upstream bit FIFO head/occupancy/pop plus the word write port.
// The word_is_data flag exists only when PACK_FLAG_EN is defined.
interface bit_word_packer_if #(
    parameter int WORD_W = 12,
    parameter int CNT_W  = 15
);
    logic              bit_data;
    logic [CNT_W-1:0]  bits_used;
    logic              bit_req;
    logic              data_request;
    logic [WORD_W-1:0] data;
    logic              data_ready;
`ifdef PACK_FLAG_EN
    logic              word_is_data;
`endif

    modport master (
        input  bit_data,
        input  bits_used,
        input  data_request,
        output bit_req,
        output data,
        output data_ready
`ifdef PACK_FLAG_EN
        ,
        output word_is_data
`endif
    );

    modport slave (
        output bit_data,
        output bits_used,
        output data_request,
        input  bit_req,
        input  data,
        input  data_ready
`ifdef PACK_FLAG_EN
        ,
        input  word_is_data
`endif
    );
endinterface

// File: rtl/bit_word_packer.sv
// Serial-to-parallel telemetry word packer: pulls WORD_W bits MSB-first per request.
// Optional macro PACK_FLAG_EN adds word_is_data (1 when no bit of the word was padding).
module bit_word_packer #(
    parameter int WORD_W    = 12,
    parameter int CNT_W     = 15,
    parameter int FILL_TH   = 10416,
    parameter int DRAIN_LEN = 10415,
    parameter int READY_LEN = 6
) (
    input  logic              clk,
    input  logic              reset,
    bit_word_packer_if.master bus
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] FILL_C  = CNT_W'(FILL_TH);
    localparam logic [CNT_W-1:0] DRAIN_C = CNT_W'(DRAIN_LEN);

    typedef enum logic [1:0] {IDLE, FETCH, PLACE, READY} state_t;

    state_t            state_q;
    logic              reqMeta_q;
    logic              reqSync_q;
    logic              reqPrev_q;
    logic              stream_q;
    logic [CNT_W-1:0]  taken_q;
    logic [IDX_W-1:0]  idx_q;
    logic              bit_q;
    logic              bitReq_q;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] data_q;
    logic              ready_q;
    logic [7:0]        readyCnt_q;
`ifdef PACK_FLAG_EN
    logic              allData_q;
    logic              flag_q;
`endif

    logic              reqRise;
    logic              drainHit;
    logic              stream_d;
    logic              fetchTake;
    logic [WORD_W-1:0] placed;

    assign reqRise   = reqSync_q & ~reqPrev_q;
    assign drainHit  = (state_q == FETCH) && (taken_q == DRAIN_C);
    // Reaching the drain length in FETCH overrides a simultaneous fill-threshold set.
    assign stream_d  = drainHit ? 1'b0 : (stream_q | (bus.bits_used > FILL_C));
    // Decided one edge ahead so bit_req is a registered strobe for the whole FETCH cycle.
    assign fetchTake = stream_d && (taken_q < DRAIN_C);

    always_comb begin
        placed        = shift_q;
        placed[idx_q] = bit_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            reqMeta_q  <= 1'b0;
            reqSync_q  <= 1'b0;
            reqPrev_q  <= 1'b0;
            stream_q   <= 1'b0;
            taken_q    <= '0;
            idx_q      <= '0;
            bit_q      <= 1'b0;
            bitReq_q   <= 1'b0;
            shift_q    <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            readyCnt_q <= '0;
`ifdef PACK_FLAG_EN
            allData_q  <= 1'b0;
            flag_q     <= 1'b0;
`endif
        end else begin
            reqMeta_q <= bus.data_request;
            reqSync_q <= reqMeta_q;
            reqPrev_q <= reqSync_q;
            stream_q  <= stream_d;
            case (state_q)
                IDLE: begin
                    if (reqRise) begin
                        state_q  <= FETCH;
                        idx_q    <= IDX_W'(WORD_W - 1);
                        bitReq_q <= fetchTake;
`ifdef PACK_FLAG_EN
                        allData_q <= 1'b1;
`endif
                    end
                end
                FETCH: begin
                    state_q  <= PLACE;
                    bitReq_q <= 1'b0;
                    if (bitReq_q) begin
                        bit_q   <= bus.bit_data;
                        taken_q <= taken_q + CNT_W'(1);
                    end else begin
                        bit_q   <= 1'b0;
                        taken_q <= '0;
`ifdef PACK_FLAG_EN
                        allData_q <= 1'b0;
`endif
                    end
                end
                PLACE: begin
                    shift_q <= placed;
                    if (idx_q == '0) begin
                        state_q    <= READY;
                        data_q     <= placed;
                        ready_q    <= 1'b1;
                        readyCnt_q <= 8'(READY_LEN - 1);
`ifdef PACK_FLAG_EN
                        flag_q     <= allData_q;
`endif
                    end else begin
                        state_q  <= FETCH;
                        idx_q    <= idx_q - IDX_W'(1);
                        bitReq_q <= fetchTake;
                    end
                end
                READY: begin
                    if (readyCnt_q == '0) begin
                        ready_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        readyCnt_q <= readyCnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.bit_req    = bitReq_q;
    assign bus.data       = data_q;
    assign bus.data_ready = ready_q;
`ifdef PACK_FLAG_EN
    assign bus.word_is_data = flag_q;
`endif
endmodule

// File: tb/tb_bit_word_packer.sv
// Scoreboard bench for bit_word_packer: default instance A and a 16-bit, short-drain instance B.
module tb_bit_word_packer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bit_word_packer_if #(.WORD_W(12), .CNT_W(15)) busA ();
    bit_word_packer_if #(.WORD_W(16), .CNT_W(15)) busB ();

    bit_word_packer u_dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA)
    );

    bit_word_packer #(
        .WORD_W(16), .CNT_W(15), .FILL_TH(100), .DRAIN_LEN(21), .READY_LEN(1)
    ) u_dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB)
    );

    typedef struct {
        logic [31:0] word;
        int          pulses;
        logic        flag;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    exp_t curA;
    exp_t curB;
    int   checkCount = 0;
    int   failCount  = 0;
    int   srcIdxA    = 0;
    int   pulsesA    = 0;
    int   pulsesB    = 0;
    int   widthA     = 0;
    int   widthB     = 0;
    int   burstsA    = 0;
    int   burstsB    = 0;
    logic prevReadyA = 1'b0;
    logic prevReadyB = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Alternating 1,0,1,0 source: the word that the next 12 pops from index start will form.
    function automatic logic [31:0] altWord(input int start);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 12; i++) w[11-i] = ((start + i) % 2 == 0);
        return w;
    endfunction

    // Upstream FIFO model for A: advance the head after each edge that pops a bit.
    initial begin
        busA.bit_data = 1'b1;
        forever begin
            @(negedge clk);
            if (busA.bit_req === 1'b1) begin
                @(posedge clk);
                #1;
                srcIdxA++;
                busA.bit_data = ~srcIdxA[0];
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (busA.bit_req === 1'b1) pulsesA++;
            if (busA.data_ready && !prevReadyA) begin
                burstsA++;
                checkOutput("A burst expected", 32'(qA.size() != 0), 1);
                if (qA.size() != 0) begin
                    curA = qA.pop_front();
                    checkOutput("A bit_req pulses", pulsesA, curA.pulses);
`ifdef PACK_FLAG_EN
                    checkOutput("A word_is_data", busA.word_is_data, curA.flag);
`endif
                end
                pulsesA = 0;
                widthA  = 0;
            end
            if (busA.data_ready) begin
                widthA++;
                checkOutput("A data", busA.data, curA.word);
            end
            if (!busA.data_ready && prevReadyA) checkOutput("A ready width", widthA, 6);
            prevReadyA = busA.data_ready;
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (busB.bit_req === 1'b1) pulsesB++;
            if (busB.data_ready && !prevReadyB) begin
                burstsB++;
                checkOutput("B burst expected", 32'(qB.size() != 0), 1);
                if (qB.size() != 0) begin
                    curB = qB.pop_front();
                    checkOutput("B bit_req pulses", pulsesB, curB.pulses);
`ifdef PACK_FLAG_EN
                    checkOutput("B word_is_data", busB.word_is_data, curB.flag);
`endif
                end
                pulsesB = 0;
                widthB  = 0;
            end
            if (busB.data_ready) begin
                widthB++;
                checkOutput("B data", busB.data, curB.word);
            end
            if (!busB.data_ready && prevReadyB) checkOutput("B ready width", widthB, 1);
            prevReadyB = busB.data_ready;
        end
    end

    task automatic pulseRequest(input int dut);
        if (dut == 0) busA.data_request = 1'b1;
        else          busB.data_request = 1'b1;
        repeat (4) @(negedge clk);
        if (dut == 0) busA.data_request = 1'b0;
        else          busB.data_request = 1'b0;
    endtask

    task automatic applyStimulus(input int dut, input logic [31:0] word, input int pulses, input logic flag);
        exp_t e;
        e.word   = word;
        e.pulses = pulses;
        e.flag   = flag;
        if (dut == 0) qA.push_back(e);
        else          qB.push_back(e);
        pulseRequest(dut);
    endtask

    task automatic waitDone(input int dut);
        int cycles;
        bit done;
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (dut == 0) done = (qA.size() == 0) && !busA.data_ready;
            else          done = (qB.size() == 0) && !busB.data_ready;
        end
        @(negedge clk);
        checkOutput(dut == 0 ? "A word completes" : "B word completes", 32'(done), 1);
    endtask

    initial begin
        bit seen;
        reset             = 1'b1;
        busA.data_request = 1'b0;
        busA.bits_used    = '0;
        busB.data_request = 1'b0;
        busB.bits_used    = '0;
        busB.bit_data     = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("A reset bit_req", busA.bit_req, 0);
        checkOutput("A reset data", busA.data, 0);
        checkOutput("A reset data_ready", busA.data_ready, 0);
        checkOutput("B reset data", busB.data, 0);
`ifdef PACK_FLAG_EN
        checkOutput("A reset word_is_data", busA.word_is_data, 0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] below-threshold request pads with zeroes");
        busA.bits_used = 15'd100;
        applyStimulus(0, 32'h000, 0, 1'b0);
        waitDone(0);

        $display("[TB] streaming alternating bits");
        busA.bits_used = 15'd10417;
        repeat (2) @(negedge clk);
        applyStimulus(0, altWord(srcIdxA), 12, 1'b1);
        waitDone(0);
        checkOutput("A data holds 0xAAA", busA.data, 32'hAAA);

        $display("[TB] second request during assembly is dropped");
        applyStimulus(0, altWord(srcIdxA), 12, 1'b1);
        repeat (4) @(negedge clk);
        pulseRequest(0);
        waitDone(0);
        repeat (80) @(negedge clk);
        checkOutput("A burst count", burstsA, 3);

        $display("[TB] reset in the middle of a word");
        busA.bits_used = 15'd12000;
        pulseRequest(0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (busA.bit_req === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("A bit_req before reset", 32'(seen), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("A mid-word reset bit_req", busA.bit_req, 0);
        checkOutput("A mid-word reset data", busA.data, 0);
        checkOutput("A mid-word reset data_ready", busA.data_ready, 0);
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        pulsesA = 0;
        repeat (3) @(negedge clk);
        applyStimulus(0, altWord(srcIdxA), 12, 1'b1);
        waitDone(0);
        checkOutput("A burst count after reset", burstsA, 4);

        $display("[TB] 16-bit instance, one-cycle strobe and drain boundary");
        busB.bits_used = 15'd200;
        repeat (2) @(negedge clk);
        applyStimulus(1, 32'hFFFF, 16, 1'b1);
        waitDone(1);
        busB.bits_used = 15'd0;
        applyStimulus(1, 32'hF800, 5, 1'b0);
        waitDone(1);
        applyStimulus(1, 32'h0000, 0, 1'b0);
        waitDone(1);
        busB.bits_used = 15'd200;
        repeat (2) @(negedge clk);
        applyStimulus(1, 32'hFFFF, 16, 1'b1);
        waitDone(1);
        checkOutput("B burst count", burstsB, 4);
        checkOutput("A scoreboard empty", qA.size(), 0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule
